// File: rtl/dly_mem_scheduler_if.sv
// Port bundle between the delay scheduler and the single-port delay sample memory.
// The memory has a synchronous read: mem_rd_data follows mem_addr by one clock.
interface dly_mem_scheduler_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/dly_mem_scheduler.sv
// Time-division scheduler for a delay memory shared by NUM_CH channels.
// Each frame visits every channel in turn: one delayed-sample read, then one new-sample write.
module dly_mem_scheduler #(
    parameter int NUM_CH    = 2,
    parameter int REGION_W  = 14,
    parameter int DATA_W    = 16,
    parameter int MIN_DELAY = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid,
    input  logic [NUM_CH*REGION_W-1:0]   delay_len,
    input  logic [NUM_CH*DATA_W-1:0]     ch_wr_data,
    input  logic                         ovr_clr,
    dly_mem_scheduler_if.master          mem,
    output logic [NUM_CH*DATA_W-1:0]     rd_data,
    output logic [NUM_CH-1:0]            rd_valid,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                           state_q, state_d;
    logic                             valid_q, valid_d;
    logic [CH_W-1:0]                  ch_q, ch_d;
    logic [NUM_CH-1:0][REGION_W-1:0]  dl_q, dl_d;
    logic [NUM_CH-1:0][REGION_W-1:0]  wp_q, wp_d;
    logic [NUM_CH-1:0][DATA_W-1:0]    wd_q, wd_d;
    logic [NUM_CH-1:0][DATA_W-1:0]    rd_data_q, rd_data_d;
    logic [NUM_CH-1:0]                rd_valid_q, rd_valid_d;
    logic                             frame_done_q, frame_done_d;
    logic                             overrun_q, overrun_d;
    logic [NUM_CH-1:0][REGION_W-1:0]  rp;
    logic                             start;

    // Read offset per channel; subtraction wraps naturally inside the region.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rp
        logic [REGION_W-1:0] dl_c;
        assign dl_c   = (dl_q[gi] < REGION_W'(MIN_DELAY)) ? REGION_W'(MIN_DELAY) : dl_q[gi];
        assign rp[gi] = wp_q[gi] - dl_c;
    end

    assign start = valid & ~valid_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid;
        ch_d         = ch_q;
        dl_d         = dl_q;
        wp_d         = wp_q;
        wd_d         = wd_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = '0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        if (ovr_clr)
            overrun_d = 1'b0;
        // An edge landing on the frame_done cycle is treated as colliding with the frame.
        if (start && (state_q != IDLE || frame_done_q))
            overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start && !frame_done_q) begin
                    dl_d    = delay_len;
                    wd_d    = ch_wr_data;
                    ch_d    = '0;
                    state_d = RD;
                end
            end
            RD: state_d = WR;
            WR: begin
                rd_data_d[ch_q]  = mem.mem_rd_data;
                rd_valid_d[ch_q] = 1'b1;
                wp_d[ch_q]       = wp_q[ch_q] + REGION_W'(1);
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory port decoded only from registered state.
    always_comb begin
        mem.mem_addr    = '0;
        mem.mem_wr_en   = 1'b0;
        mem.mem_wr_data = '0;
        case (state_q)
            RD: mem.mem_addr = {ch_q, rp[ch_q]};
            WR: begin
                mem.mem_addr    = {ch_q, wp_q[ch_q]};
                mem.mem_wr_en   = 1'b1;
                mem.mem_wr_data = wd_q[ch_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            ch_q         <= '0;
            dl_q         <= '0;
            wp_q         <= '0;
            wd_q         <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            ch_q         <= ch_d;
            dl_q         <= dl_d;
            wp_q         <= wp_d;
            wd_q         <= wd_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
endmodule
